// File: rtl/difftest_commit_sequencer_if.sv
// Commit-beat bus between the two-slot retire stage and the difftest consumer.
// master drives commits and accepts queue entries; slave is the sequencer.
interface difftest_commit_sequencer_if;
    logic [1:0]  in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [63:0] in_npc;
    logic [63:0] in_inst;
    logic [9:0]  in_rdIdx;
    logic [1:0]  in_wen;
    logic [63:0] in_wdata;
    logic [1:0]  in_skip;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic [31:0] out_inst;
    logic [31:0] out_wdata;
    logic [4:0]  out_rdIdx;
    logic        out_wen;
    logic        out_skip;

    modport master (
        output in_valid, in_pc, in_npc, in_inst, in_rdIdx, in_wen, in_wdata, in_skip,
        input  in_ready,
        input  out_valid, out_pc, out_npc, out_inst, out_wdata, out_rdIdx, out_wen, out_skip,
        output out_ready
    );

    modport slave (
        input  in_valid, in_pc, in_npc, in_inst, in_rdIdx, in_wen, in_wdata, in_skip,
        output in_ready,
        output out_valid, out_pc, out_npc, out_inst, out_wdata, out_rdIdx, out_wen, out_skip,
        input  out_ready
    );
endinterface

// File: rtl/difftest_commit_sequencer.sv
// Serialises two-slot commit beats into a single-entry difftest stream with idle timeout.
// Optional PC continuity checker enabled by defining DIFFTEST_PC_CHECK_EN.
module difftest_commit_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    difftest_commit_sequencer_if.slave bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    timeout,
    output logic                    pc_mismatch
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        wen;
        logic        skip;
    } entry_t;

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    entry_t mem [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
    state_t            state_q, state_d;

    entry_t     slot0, slot1, first_e, head_e;
    logic       accept, pop, wr_second;
    logic [1:0] push_n;

    always_comb begin
        slot0 = '{pc: bus.in_pc[31:0], npc: bus.in_npc[31:0], inst: bus.in_inst[31:0],
                  wdata: bus.in_wdata[31:0], rd: bus.in_rdIdx[4:0],
                  wen: bus.in_wen[0], skip: bus.in_skip[0]};
        slot1 = '{pc: bus.in_pc[63:32], npc: bus.in_npc[63:32], inst: bus.in_inst[63:32],
                  wdata: bus.in_wdata[63:32], rd: bus.in_rdIdx[9:5],
                  wen: bus.in_wen[1], skip: bus.in_skip[1]};
        // A lone slot1 commit is compacted down to the tail position.
        first_e   = bus.in_valid[0] ? slot0 : slot1;
        accept    = bus.in_ready && (bus.in_valid != 2'b00);
        wr_second = accept && (bus.in_valid == 2'b11);
        push_n    = !accept ? 2'd0 : (wr_second ? 2'd2 : 2'd1);
        pop       = bus.out_valid && bus.out_ready;
        head_e    = mem[head_q];
    end

    always_comb begin
        head_d    = head_q + PTR_W'(pop);
        tail_d    = tail_q + PTR_W'(push_n);
        count_d   = count_q + CNT_W'(push_n) - CNT_W'(pop);
        idle_d    = idle_q;
        if (accept) begin
            idle_d = '0;
        end else if (idle_q != IDLE_W'(TIMEOUT)) begin
            idle_d = idle_q + IDLE_W'(1);
        end
        timeout_d = timeout_q | (idle_d == IDLE_W'(TIMEOUT));
        state_d   = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_DRAIN;
            S_DRAIN: if (pop && !accept && count_q == CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
            state_q   <= S_IDLE;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
            state_q   <= state_d;
        end
    end

    // Payload storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[tail_q] <= first_e;
        end
        if (wr_second) begin
            mem[tail_q + PTR_W'(1)] <= slot1;
        end
    end

    assign bus.in_ready  = (count_q <= CNT_W'(DEPTH - 2));
    assign bus.out_valid = (state_q == S_DRAIN);
    assign bus.out_pc    = head_e.pc;
    assign bus.out_npc   = head_e.npc;
    assign bus.out_inst  = head_e.inst;
    assign bus.out_wdata = head_e.wdata;
    assign bus.out_rdIdx = head_e.rd;
    assign bus.out_wen   = head_e.wen;
    assign bus.out_skip  = head_e.skip;
    assign count         = count_q;
    assign timeout       = timeout_q;

`ifdef DIFFTEST_PC_CHECK_EN
    logic [31:0] prev_npc_q, prev_npc_d;
    logic        prev_valid_q, prev_valid_d;
    logic        pc_mismatch_q, pc_mismatch_d;

    always_comb begin
        prev_npc_d    = prev_npc_q;
        prev_valid_d  = prev_valid_q;
        pc_mismatch_d = pc_mismatch_q;
        if (pop) begin
            prev_npc_d   = head_e.npc;
            prev_valid_d = 1'b1;
            // Skipped entries may legitimately break the PC chain (e.g. MMIO, interrupts).
            if (prev_valid_q && (head_e.pc != prev_npc_q) && !head_e.skip) begin
                pc_mismatch_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_valid_q  <= 1'b0;
            pc_mismatch_q <= 1'b0;
        end else begin
            prev_valid_q  <= prev_valid_d;
            pc_mismatch_q <= pc_mismatch_d;
        end
    end

    always_ff @(posedge clock) begin
        prev_npc_q <= prev_npc_d;
    end

    assign pc_mismatch = pc_mismatch_q;
`else
    assign pc_mismatch = 1'b0;
`endif
endmodule
